kappa3_dbg_responder: RTL
=========================

KAPPA3_DBG_RESPONDER -- requirements
Module: kappa3_dbg_responder

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, max cycles to wait for mem_ack before abort.
REQ-002 SHALL have parameter AW, default 32, memory address width.
REQ-003 SHALL use one clock, `clock`; reset is `reset`, asynchronous, active-high.
REQ-004 SHALL have ports: clock in 1 system clock; reset in 1 async active-high reset.
REQ-005 SHALL have ports: running in 1 core executing (debug access refused); dbg_in in 32 host write data.
REQ-006 SHALL have ports: dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write in 1 each, host strobe levels.
REQ-007 SHALL have ports: dbg_reg_addr in 5; dbg_mem_addr in AW.
REQ-008 SHALL have ports: dbg_reg_out out 32; dbg_mem_out out 32; busy out 1; err out 1 sticky.
REQ-009 SHALL have core-side ports: pc_ld out 1; pc_d out 32; rf_we out 1; rf_waddr out 5; rf_wdata out 32; rf_raddr out 5; rf_rdata in 32.
REQ-010 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out AW; mem_wdata out 32; mem_ack in 1; mem_rdata in 32.

Function
REQ-011 SHALL register each strobe and act only on its rising edge (0 then 1 on consecutive clocks); held-high strobes act once.
REQ-012 SHALL capture dbg_in, dbg_reg_addr and dbg_mem_addr in the edge-detect cycle.
REQ-013 SHALL use FSM IDLE, REG, MEM_REQ, MEM_WAIT, DONE; DONE returns to IDLE after one cycle.
REQ-014 SHALL assert busy in every state except IDLE.
REQ-015 SHALL, in IDLE with simultaneous edges, serve priority pc > reg > mem_write > mem_read and drop the others with err set.
REQ-016 SHALL ignore edges arriving while busy and set err.
REQ-017 SHALL ignore edges while running=1 and set err; no core-side or memory strobe issued.
REQ-018 SHALL, on pc edge, pulse pc_ld for exactly one cycle with pc_d = captured dbg_in, in the cycle after the edge.
REQ-019 SHALL, on reg edge, enter REG and pulse rf_we for one cycle with rf_waddr/rf_wdata captured; write to address 0 is still issued (core discards).
REQ-020 SHALL drive rf_raddr = dbg_reg_addr continuously and register dbg_reg_out <= rf_rdata every cycle (one-cycle read latency).
REQ-021 SHALL, on mem edge, hold mem_req=1 with stable mem_we/mem_addr/mem_wdata from MEM_REQ until the cycle mem_ack=1 (inclusive).
REQ-022 SHALL, on mem_ack during a read, load dbg_mem_out <= mem_rdata; dbg_mem_out holds otherwise, and writes leave it unchanged.
REQ-023 SHALL count wait cycles from mem_req assertion; if ACK_TIMEOUT cycles pass without mem_ack, drop mem_req, set err, go DONE, keep dbg_mem_out.
REQ-024 SHALL accept mem_ack in the first mem_req cycle (zero-wait memory); latency strobe-edge to DONE then 3 cycles.
REQ-025 SHALL ignore mem_ack outside MEM_REQ/MEM_WAIT.
REQ-026 SHALL clear err only by reset.

Reset
REQ-027 SHALL on reset asynchronously force: state IDLE, busy 0, err 0, pc_ld 0, rf_we 0, mem_req 0, mem_we 0, dbg_reg_out 0, dbg_mem_out 0, timeout counter 0, strobe history 0.
REQ-028 SHALL, on reset mid-transaction, drop mem_req immediately and not retry after release.
REQ-029 SHALL treat a strobe already high at reset release as non-edge (no action until it falls and rises).

Structure
REQ-030 SHALL place FSM state encoding and the op code enum (OP_PC, OP_REG, OP_MWR, OP_MRD) in shared package kappa3_dbg_pkg.
REQ-031 SHALL implement edge detection in one sub-module dbg_edge_detect, instantiated per strobe.

Verification
REQ-032 Bench: running=0, dbg_in=0x00000100, pc strobe high 1 cycle -> pc_ld one pulse, pc_d=0x00000100, busy 2 cycles, err 0.
REQ-033 Bench: reg strobe addr 5 data 0xDEADBEEF, rf model -> rf_we one pulse addr 5; next cycles dbg_reg_out=0xDEADBEEF.
REQ-034 Bench: mem write 0x10=0x12345678 then read 0x10, 2-cycle ack memory -> dbg_mem_out=0x12345678, mem_req held 3 cycles each.
REQ-035 Bench: mem read, mem_ack never -> mem_req drops after 15 cycles, err=1, dbg_mem_out unchanged, FSM IDLE.
REQ-036 Bench: pc and mem_read edges same cycle, then any strobe while running=1 -> only pc_ld issued, err=1, no mem_req.
REQ-037 Bench: reset asserted during MEM_WAIT -> mem_req 0 same cycle, all outputs at reset values, no request after release.

Source files
------------

// File: rtl/kappa3_dbg_pkg.sv
// kappa3_dbg_pkg: shared FSM state and debug op encodings for the debug responder
package kappa3_dbg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REG, S_MEM_REQ, S_MEM_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_PC, OP_REG, OP_MWR, OP_MRD} op_t;
endpackage

// File: rtl/dbg_edge_detect.sv
// dbg_edge_detect: registered rising-edge detector for one host strobe level
module dbg_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_strobe,
  output logic o_edge
);
  logic r_prev, r_arm;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= i_strobe;
      r_arm  <= 1'b1;
    end
  // r_arm masks the first clock after reset so a level already high is not an edge
  assign o_edge = r_arm & i_strobe & ~r_prev;
endmodule

// File: rtl/kappa3_dbg_responder.sv
// kappa3_dbg_responder: host debug strobes to core PC/register writes and memory accesses
module kappa3_dbg_responder
  import kappa3_dbg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int AW          = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          running,
  input  logic [31:0]   dbg_in,
  input  logic          dbg_pc_ld,
  input  logic          dbg_reg_ld,
  input  logic          dbg_mem_read,
  input  logic          dbg_mem_write,
  input  logic [4:0]    dbg_reg_addr,
  input  logic [AW-1:0] dbg_mem_addr,
  output logic [31:0]   dbg_reg_out,
  output logic [31:0]   dbg_mem_out,
  output logic          busy,
  output logic          err,
  output logic          pc_ld,
  output logic [31:0]   pc_d,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic [4:0]    rf_raddr,
  input  logic [31:0]   rf_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  state_t        r_state, w_next;
  op_t           r_op, w_op;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_data, r_reg_out, r_mem_out;
  logic [AW-1:0] r_addr;
  logic [4:0]    r_waddr;
  logic          r_err;
  logic [3:0]    w_strb, w_edge;
  logic          w_any, w_idle, w_multi, w_accept, w_mem, w_timeout, w_err;
  assign w_strb = {dbg_mem_read, dbg_mem_write, dbg_reg_ld, dbg_pc_ld};
  for (genvar i = 0; i < 4; i++) begin : g_ed
    dbg_edge_detect u_ed (
      .clock   (clock),
      .reset   (reset),
      .i_strobe(w_strb[i]),
      .o_edge  (w_edge[i])
    );
  end
  assign w_any    = |w_edge;
  assign w_idle   = r_state == S_IDLE;
  assign w_mem    = r_state == S_MEM_REQ || r_state == S_MEM_WAIT;
  assign w_multi  = (w_edge & (w_edge - 4'd1)) != 4'd0;
  assign w_accept = w_any & w_idle & ~running;
  assign w_op     = w_edge[0] ? OP_PC : w_edge[1] ? OP_REG : w_edge[2] ? OP_MWR : OP_MRD;
  // Dropped edges (busy, running, lower priority) and timeouts all flag err
  assign w_err    = (w_any & (~w_idle | running | w_multi)) | w_timeout;
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_accept) w_next = (w_op == OP_PC || w_op == OP_REG) ? S_REG : S_MEM_REQ;
      S_REG: w_next = S_DONE;
      S_MEM_REQ, S_MEM_WAIT:
        if (mem_ack) w_next = S_DONE;
        else if (r_cnt == CNT_LAST) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end else w_next = S_MEM_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_PC;
      r_cnt     <= '0;
      r_data    <= '0;
      r_addr    <= '0;
      r_waddr   <= '0;
      r_err     <= 1'b0;
      r_reg_out <= '0;
      r_mem_out <= '0;
    end else begin
      r_state   <= w_next;
      r_err     <= r_err | w_err;
      r_reg_out <= rf_rdata;
      r_cnt     <= w_mem ? r_cnt + CW'(1) : '0;
      if (w_accept) begin
        r_op    <= w_op;
        r_data  <= dbg_in;
        r_addr  <= dbg_mem_addr;
        r_waddr <= dbg_reg_addr;
      end
      if (w_mem && mem_ack && r_op == OP_MRD) r_mem_out <= mem_rdata;
    end
  assign busy        = ~w_idle;
  assign err         = r_err;
  assign pc_ld       = r_state == S_REG && r_op == OP_PC;
  assign rf_we       = r_state == S_REG && r_op == OP_REG;
  assign pc_d        = r_data;
  assign rf_waddr    = r_waddr;
  assign rf_wdata    = r_data;
  assign rf_raddr    = dbg_reg_addr;
  assign dbg_reg_out = r_reg_out;
  assign dbg_mem_out = r_mem_out;
  assign mem_req     = w_mem;
  assign mem_we      = w_mem && r_op == OP_MWR;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_data;
endmodule
